// File: rtl/object_draw_scanner.sv
// object_draw_scanner
//   Walks every object slot. For each active slot it streams one pixel per
//   clock for a BLK_W x BLK_H block at (x_k, y_k) to the VGA plot port.
//   Pixels that fall off the screen still take their cycle but have plot=0.
//   The game control FSM starts a pass with start, watches busy, and waits
//   for the one-cycle done pulse. An erase pass is the same walk with colour 0.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   start      one-cycle request to begin a scan (only honoured in IDLE)
//   x_bus      packed x coordinates, slot k at [8k+7:8k]
//   y_bus      packed y coordinates, slot k at [7k+6:7k]
//   active     slot k is drawn only when active[k]=1
//   colour_in  colour for this pass
//   plot_x     pixel x to VGA
//   plot_y     pixel y to VGA
//   colour     pixel colour to VGA
//   plot       VGA write enable, at most one pixel per cycle
//   busy       high in every non-IDLE state
//   done       one-cycle pulse at the end of a scan
module object_draw_scanner #(
  parameter int NUM_OBJ = 10,
  parameter int BLK_W   = 8,
  parameter int BLK_H   = 8,
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*NUM_OBJ-1:0] x_bus,
  input  logic [7*NUM_OBJ-1:0] y_bus,
  input  logic [NUM_OBJ-1:0]   active,
  input  logic [2:0]           colour_in,
  output logic [7:0]           plot_x,
  output logic [6:0]           plot_y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 done
);

  localparam int SLOT_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int DX_W   = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int DY_W   = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_OBJ - 1);
  localparam logic [DX_W-1:0]   LAST_DX   = DX_W'(BLK_W - 1);
  localparam logic [DY_W-1:0]   LAST_DY   = DY_W'(BLK_H - 1);

  typedef enum logic [1:0] {IDLE, SELECT, DRAW, DONE} state_t;

  state_t state, next_state;

  logic [SLOT_W-1:0] slot, next_slot;
  logic [DX_W-1:0]   dx, next_dx;
  logic [DY_W-1:0]   dy, next_dy;

  // Snapshot of the coordinate registers taken when a scan starts, so the
  // game logic may move objects while the pass is still drawing.
  logic [NUM_OBJ-1:0][7:0] x_snap;
  logic [NUM_OBJ-1:0][6:0] y_snap;
  logic [NUM_OBJ-1:0]      active_snap;
  logic [2:0]              colour_snap;
  logic                    snap_en;

  logic       last_slot;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       pix_on;

  assign last_slot = (slot == LAST_SLOT);

  // Next-state logic. The pixel outputs are registered, so they are
  // computed from the *next* slot/dx/dy: the value shown during a DRAW
  // cycle belongs to that same cycle's pixel.
  always_comb begin
    next_state = state;
    next_slot  = slot;
    next_dx    = dx;
    next_dy    = dy;
    snap_en    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          snap_en    = 1'b1;
          next_slot  = '0;
          next_state = SELECT;
        end
      end

      SELECT: begin
        if (active_snap[slot]) begin
          next_dx    = '0;
          next_dy    = '0;
          next_state = DRAW;
        end else if (last_slot) begin
          next_state = DONE;
        end else begin
          next_slot = slot + SLOT_W'(1);
        end
      end

      DRAW: begin
        if (dx == LAST_DX) begin
          next_dx = '0;
          if (dy == LAST_DY) begin
            next_dy = '0;
            if (last_slot) begin
              next_state = DONE;
            end else begin
              next_slot  = slot + SLOT_W'(1);
              next_state = SELECT;
            end
          end else begin
            next_dy = dy + DY_W'(1);
          end
        end else begin
          next_dx = dx + DX_W'(1);
        end
      end

      DONE: next_state = IDLE;

      default: next_state = IDLE;
    endcase

    // Widened sums so that blocks hanging off the right/bottom edge are
    // detected before the value is truncated to the VGA port widths.
    sum_x  = {1'b0, x_snap[next_slot]} + 9'(next_dx);
    sum_y  = {1'b0, y_snap[next_slot]} + 8'(next_dy);
    pix_on = (next_state == DRAW) &&
             (int'(sum_x) < SCR_W) && (int'(sum_y) < SCR_H);
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      slot        <= '0;
      dx          <= '0;
      dy          <= '0;
      x_snap      <= '0;
      y_snap      <= '0;
      active_snap <= '0;
      colour_snap <= '0;
      plot_x      <= '0;
      plot_y      <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= next_state;
      slot  <= next_slot;
      dx    <= next_dx;
      dy    <= next_dy;

      if (snap_en) begin
        x_snap      <= x_bus;
        y_snap      <= y_bus;
        active_snap <= active;
        colour_snap <= colour_in;
      end

      plot <= pix_on;
      busy <= (next_state != IDLE);
      done <= (next_state == DONE);

      if (next_state == DRAW) begin
        plot_x <= sum_x[7:0];
        plot_y <= sum_y[6:0];
        colour <= colour_snap;
      end
    end
  end

endmodule

// File: tb/tb_object_draw_scanner.sv
// Testbench for object_draw_scanner.
// Expected pixel streams come from a closed-form model: slot k's select
// cycle is k+1 plus 64 per earlier active slot, its pixels follow in
// raster order, and done lands at NUM_OBJ + A*BLK_W*BLK_H + 1.
module tb_object_draw_scanner;

  localparam int NUM_OBJ = 10;
  localparam int BLK_W   = 8;
  localparam int BLK_H   = 8;
  localparam int SCR_W   = 160;
  localparam int SCR_H   = 120;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [8*NUM_OBJ-1:0] x_bus;
  logic [7*NUM_OBJ-1:0] y_bus;
  logic [NUM_OBJ-1:0]   active;
  logic [2:0]           colour_in;
  logic [7:0]           plot_x;
  logic [6:0]           plot_y;
  logic [2:0]           colour;
  logic                 plot;
  logic                 busy;
  logic                 done;

  int tests = 0;
  int fails = 0;

  // Scenario description consumed by do_scan
  int                 tx[NUM_OBJ];
  int                 ty[NUM_OBJ];
  logic [NUM_OBJ-1:0] tact;
  logic [2:0]         tcol;

  object_draw_scanner #(
    .NUM_OBJ(NUM_OBJ), .BLK_W(BLK_W), .BLK_H(BLK_H),
    .SCR_W(SCR_W), .SCR_H(SCR_H)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_bus(x_bus), .y_bus(y_bus), .active(active), .colour_in(colour_in),
    .plot_x(plot_x), .plot_y(plot_y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic drive_bus();
    for (int k = 0; k < NUM_OBJ; k++) begin
      x_bus[8*k +: 8] = 8'(tx[k]);
      y_bus[7*k +: 7] = 7'(ty[k]);
    end
    active    = tact;
    colour_in = tcol;
  endtask

  task automatic scramble_bus();
    for (int k = 0; k < NUM_OBJ; k++) begin
      x_bus[8*k +: 8] = 8'($urandom);
      y_bus[7*k +: 7] = 7'($urandom);
    end
    active    = NUM_OBJ'($urandom);
    colour_in = 3'($urandom);
  endtask

  // Run one complete scan and compare every cycle against the model.
  // scramble: change the input buses every cycle after start.
  // extra_start: cycle at which a second start is pulsed (0 = never).
  task automatic do_scan(input string name, input bit scramble, input int extra_start);
    int a_cnt = 0;
    int done_cyc;
    int base = 0;
    int exp_pulses = 0;
    int got_pulses = 0;
    int got_dones = 0;
    bit e_draw[];
    bit e_plot[];
    int e_x[];
    int e_y[];

    for (int k = 0; k < NUM_OBJ; k++) if (tact[k]) a_cnt++;
    done_cyc = NUM_OBJ + a_cnt * BLK_W * BLK_H + 1;
    e_draw = new[done_cyc + 4];
    e_plot = new[done_cyc + 4];
    e_x    = new[done_cyc + 4];
    e_y    = new[done_cyc + 4];

    for (int k = 0; k < NUM_OBJ; k++) begin
      if (tact[k]) begin
        for (int yy = 0; yy < BLK_H; yy++) begin
          for (int xx = 0; xx < BLK_W; xx++) begin
            int c  = k + 2 + base * BLK_W * BLK_H + yy * BLK_W + xx;
            int px = tx[k] + xx;
            int py = ty[k] + yy;
            e_draw[c] = 1'b1;
            e_plot[c] = (px < SCR_W) && (py < SCR_H);
            e_x[c]    = px % 256;
            e_y[c]    = py % 128;
            if (e_plot[c]) exp_pulses++;
          end
        end
        base++;
      end
    end

    @(negedge clk);
    drive_bus();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    for (int c = 1; c <= done_cyc + 3; c++) begin
      if (scramble) scramble_bus();
      start = (c == extra_start);

      tests++;
      if (plot !== e_plot[c]) begin
        fails++;
        $display("[TB] FAIL %s plot cycle %0d: got %b expected %b", name, c, plot, e_plot[c]);
      end
      tests++;
      if (done !== (c == done_cyc)) begin
        fails++;
        $display("[TB] FAIL %s done cycle %0d: got %b expected %b", name, c, done, (c == done_cyc));
      end
      tests++;
      if (busy !== (c <= done_cyc)) begin
        fails++;
        $display("[TB] FAIL %s busy cycle %0d: got %b expected %b", name, c, busy, (c <= done_cyc));
      end
      if (e_plot[c]) begin
        tests++;
        if ({plot_x, plot_y, colour} !== {8'(e_x[c]), 7'(e_y[c]), tcol}) begin
          fails++;
          $display("[TB] FAIL %s pixel cycle %0d: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                   name, c, plot_x, plot_y, colour, e_x[c], e_y[c], tcol);
        end
      end
      if (plot === 1'b1) got_pulses++;
      if (done === 1'b1) got_dones++;

      @(posedge clk);
      #1;
    end
    start = 1'b0;

    tests++;
    if (got_pulses != exp_pulses) begin
      fails++;
      $display("[TB] FAIL %s pulse count: got %0d expected %0d", name, got_pulses, exp_pulses);
    end
    tests++;
    if (got_dones != 1) begin
      fails++;
      $display("[TB] FAIL %s done count: got %0d expected 1", name, got_dones);
    end
  endtask

  task automatic clear_scenario();
    for (int k = 0; k < NUM_OBJ; k++) begin
      tx[k] = 0;
      ty[k] = 0;
    end
    tact = '0;
    tcol = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    clear_scenario();
    drive_bus();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({plot, done, busy, plot_x, plot_y, colour} !== 21'd0) begin
      fails++;
      $display("[TB] FAIL reset outputs: got plot=%b done=%b busy=%b x=%0d y=%0d c=%0d expected all 0",
               plot, done, busy, plot_x, plot_y, colour);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({plot, done, busy} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL idle after reset: got plot=%b done=%b busy=%b expected 000", plot, done, busy);
    end
  endtask

  task automatic test_no_active();
    clear_scenario();
    tcol = 3'b011;
    do_scan("no_active", 1'b0, 0);
  endtask

  task automatic test_single_slot();
    clear_scenario();
    tact[3] = 1'b1;
    tx[3]   = 32;
    ty[3]   = 10;
    tcol    = 3'b100;
    do_scan("slot3", 1'b0, 0);
  endtask

  task automatic test_all_slots_snapshot();
    clear_scenario();
    for (int k = 0; k < NUM_OBJ; k++) begin
      tx[k] = 10 * k + 2;
      ty[k] = 5 * k;
    end
    tact = '1;
    tcol = 3'b111;
    do_scan("all_slots", 1'b1, 0);
  endtask

  task automatic test_clipping();
    clear_scenario();
    tact[0] = 1'b1;
    tx[0]   = 152;
    ty[0]   = 115;
    tcol    = 3'b010;
    do_scan("clip", 1'b0, 0);
  endtask

  task automatic test_erase_double_start();
    clear_scenario();
    tact[9] = 1'b1;
    tx[9]   = 80;
    ty[9]   = 60;
    tcol    = 3'b000;
    do_scan("erase", 1'b0, 30);
  endtask

  task automatic test_reset_mid_scan();
    int bad = 0;
    clear_scenario();
    tact[2] = 1'b1;
    tact[6] = 1'b1;
    tx[2]   = 50;
    ty[2]   = 20;
    tx[6]   = 90;
    ty[6]   = 40;
    tcol    = 3'b101;

    @(negedge clk);
    drive_bus();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Slot 2 draws in cycles 4..67; stop at cycle 10
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if ({busy, plot} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL mid_reset pre-check: got busy=%b plot=%b expected 11", busy, plot);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({plot, busy, done, plot_x, plot_y, colour} !== 21'd0) begin
      fails++;
      $display("[TB] FAIL mid_reset outputs: got plot=%b busy=%b done=%b x=%0d y=%0d c=%0d expected all 0",
               plot, busy, done, plot_x, plot_y, colour);
    end
    reset = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if ({plot, busy, done} !== 3'b000) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL mid_reset aftermath: got %0d cycles with activity expected 0", bad);
    end
    do_scan("post_reset", 1'b0, 0);
  endtask

  task automatic test_random_scans();
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        tx[k] = $urandom_range(0, 255);
        ty[k] = $urandom_range(0, 127);
      end
      tact = NUM_OBJ'($urandom);
      tcol = 3'($urandom);
      do_scan($sformatf("random%0d", n), 1'b1, (n == 2) ? 15 : 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    x_bus     = '0;
    y_bus     = '0;
    active    = '0;
    colour_in = '0;

    test_reset();
    test_no_active();
    test_single_slot();
    test_all_slots_snapshot();
    test_clipping();
    test_erase_double_start();
    test_reset_mid_scan();
    test_random_scans();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/object_draw_scanner.md
Name: object_draw_scanner

Overview:
- Read side of the per-object coordinate registers; consumes the ten latched x coordinates (plus y coordinates and an active mask) and walks every slot.
- For each active slot, streams one pixel per clock to the VGA adapter for a BLK_W x BLK_H block at (x, y).
- Sits between the coordinate/position registers and the vga_adapter plot port.
- Driven by the game control FSM with a start/busy/done handshake; also used for erase passes (colour 0).

Parameters:
NUM_OBJ, 10, number of object slots scanned (slot k = x_k / y_k).
BLK_W, 8, block width in pixels.
BLK_H, 8, block height in pixels.
SCR_W, 160, screen width; pixels with x >= SCR_W are suppressed.
SCR_H, 120, screen height; pixels with y >= SCR_H are suppressed.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a frame scan; sampled only in IDLE.
x_bus  input  8*NUM_OBJ  packed x coords; slot k at [8k+7:8k].
y_bus  input  7*NUM_OBJ  packed y coords; slot k at [7k+6:7k].
active  input  NUM_OBJ  slot k drawn only if active[k]=1.
colour_in  input  3  colour for this pass (3'b000 = erase).
plot_x  output  8  pixel x to VGA.
plot_y  output  7  pixel y to VGA.
colour  output  3  pixel colour to VGA.
plot  output  1  write-enable to VGA, one pixel per cycle.
busy  output  1  high in every non-IDLE state.
done  output  1  one-cycle pulse when scan completes.

Behaviour:
- Clock, reset and outputs
  - Single clock. reset has priority over everything.
  - Reset values: state=IDLE; plot=0; done=0; busy=0; plot_x=0; plot_y=0; colour=0; slot/dx/dy counters=0.
  - All outputs are registered.
- FSM states: IDLE, SELECT, DRAW, DONE.
- IDLE: on start=1, snapshot x_bus, y_bus, active and colour_in into internal registers, set slot=0, go to SELECT. Inputs have no effect after the snapshot until the next start.
- SELECT (1 cycle per slot):
  - If active[slot], clear dx and dy, then go to DRAW.
  - Otherwise, if slot==NUM_OBJ-1, go to DONE; else slot+1 and stay in SELECT.
- DRAW (one cycle per pixel, raster order: dx increments fastest, dy after dx wraps from BLK_W-1 to 0)
  - Each DRAW cycle presents plot_x = x_slot+dx and plot_y = y_slot+dy. Sums use 9-bit and 8-bit arithmetic, truncated for output.
  - colour = snapshot colour.
  - plot = 1 only if the untruncated sums satisfy x < SCR_W and y < SCR_H. Clipped pixels still consume their cycle with plot=0.
  - After pixel (BLK_W-1, BLK_H-1): if slot==NUM_OBJ-1, go to DONE; else slot+1 and go to SELECT.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. busy drops in the cycle after the done pulse.
- Outside DRAW, plot=0.
- Latency: with A active slots and start sampled at edge 0, done is high in cycle NUM_OBJ + A*BLK_W*BLK_H + 1.
- start while busy is ignored; no queuing.
- Synchronous reset mid-scan returns to IDLE next edge: plot=0, no done pulse, snapshot discarded.
- The x range produced by the coordinate registers (2..152) never clips horizontally with BLK_W=8. Clip logic is still required for parameter changes and for y.

Test Plan:
- Reset, then start with active=0: no plot ever asserted; done pulses exactly at cycle 11 after start; busy high cycles 1-11 and low in cycle 12.
- active=10'b0000001000, slot 3 x=32 y=10, colour_in=3'b100: 64 plot pulses covering x 32..39 x y 10..17 in raster order (first (32,10), ninth (32,11), last (39,17)); colour=100 throughout; done at cycle 75.
- All slots active, x_k=10k+2, y_k=5k, colour_in=3'b111: 640 plot pulses, every block correct; done at cycle 651; change x_bus, y_bus and active mid-scan to new values → output pixels unchanged (snapshot honoured).
- Clipping, slot 0 only active, x=152 y=115: 64 DRAW cycles; plot=1 only for rows 115..119 (40 pixels); rows 120..122 have plot=0; done still at cycle 75.
- Erase pass with colour_in=0 and slot 9 active: colour=000 on all 64 pulses. A second start pulsed during the scan is ignored: only one done pulse.
- Assert reset for 1 cycle during DRAW of slot 2: next cycle plot=0, busy=0, and no done pulse. A fresh start afterwards completes normally with correct timing.
